// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// MULDIV_FAST_MUL_EN selects radix-4 Booth multiplication (16 iterations).
package muldiv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMulIter,
        StDivIter,
        StFixup,
        StDone
    } state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int unsigned XLEN = 32;

`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MUL_ITERS = XLEN / 2;
`else
    localparam int unsigned MUL_ITERS = XLEN;
`endif
    localparam int unsigned DIV_ITERS = XLEN;

    // Cycles from the accepting edge to the cycle in which done is high.
    localparam int unsigned MUL_LATENCY  = MUL_ITERS + 1;
    localparam int unsigned DIV_LATENCY  = DIV_ITERS + 2;
    localparam int unsigned DIVZ_LATENCY = 1;

endpackage

// File: rtl/muldiv_if.sv
// Control/bus-side handshake and result signals of the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_by_zero, z_hi, z_lo
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_by_zero, z_hi, z_lo
    );
endinterface

// File: rtl/nonrestoring_div_step.sv
// One non-restoring division iteration on magnitudes; purely combinational.
module nonrestoring_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH+1:0] rem_i,
    input  logic             quo_msb_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH+1:0] rem_o,
    output logic             quo_bit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] dvsr;

    always_comb begin
        shifted   = {rem_i[WIDTH:0], quo_msb_i};
        dvsr      = {2'b00, div_i};
        // Negative partial remainder adds the divisor back instead of restoring.
        rem_o     = rem_i[WIDTH+1] ? (shifted + dvsr) : (shifted - dvsr);
        quo_bit_o = ~rem_o[WIDTH+1];
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply (Booth) / divide (non-restoring) unit driving Z_HI/Z_LO.
// MULDIV_FAST_MUL_EN selects radix-4 Booth recoding for MUL.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic     clock,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned PW = AW + WIDTH + 1;
    localparam int unsigned RW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MulIters = WIDTH / 2;
`else
    localparam int unsigned MulIters = WIDTH;
`endif
    localparam logic [CW-1:0] MulLast = CW'(MulIters - 1);
    localparam logic [CW-1:0] DivLast = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] z_hi_q, z_hi_d;
    logic [WIDTH-1:0] z_lo_q, z_lo_d;
    logic             dbz_q, dbz_d;

    logic [AW-1:0]    mc_ext;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_sum;
    logic [PW-1:0]    prod_step;
    logic [RW-1:0]    step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] quo_res;
    logic [WIDTH-1:0] rem_res;

    // Booth product register: {accumulator, multiplier, booth bit}.
    always_comb begin
        mc_ext = {{2{opnd_q[WIDTH-1]}}, opnd_q};
        acc    = prod_q[PW-1 -: AW];
`ifdef MULDIV_FAST_MUL_EN
        case (prod_q[2:0])
            3'b001, 3'b010: acc_sum = acc + mc_ext;
            3'b011:         acc_sum = acc + (mc_ext << 1);
            3'b100:         acc_sum = acc - (mc_ext << 1);
            3'b101, 3'b110: acc_sum = acc - mc_ext;
            default:        acc_sum = acc;
        endcase
        prod_step = $signed({acc_sum, prod_q[PW-AW-1:0]}) >>> 2;
`else
        case (prod_q[1:0])
            2'b01:   acc_sum = acc + mc_ext;
            2'b10:   acc_sum = acc - mc_ext;
            default: acc_sum = acc;
        endcase
        prod_step = $signed({acc_sum, prod_q[PW-AW-1:0]}) >>> 1;
`endif
    end

    nonrestoring_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_msb_i(quo_q[WIDTH-1]),
        .div_i    (opnd_q),
        .rem_o    (step_rem),
        .quo_bit_o(step_qbit)
    );

    always_comb begin
        abs_a   = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
        abs_b   = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
        rem_mag = rem_q[RW-1] ? (rem_q[WIDTH-1:0] + opnd_q) : rem_q[WIDTH-1:0];
        quo_res = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        rem_res = sign_a_q ? -rem_mag : rem_mag;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        z_hi_d   = z_hi_q;
        z_lo_d   = z_lo_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dbz_d    = 1'b0;
                    sign_a_d = bus.operand_a[WIDTH-1];
                    sign_b_d = bus.operand_b[WIDTH-1];
                    if (bus.op == OP_MUL) begin
                        opnd_d  = bus.operand_a;
                        prod_d  = {{AW{1'b0}}, bus.operand_b, 1'b0};
                        cnt_d   = MulLast;
                        state_d = StMulIter;
                    end else if (bus.operand_b == '0) begin
                        dbz_d   = 1'b1;
                        z_hi_d  = bus.operand_a;
                        z_lo_d  = '1;
                        state_d = StDone;
                    end else begin
                        opnd_d  = abs_b;
                        rem_d   = '0;
                        quo_d   = abs_a;
                        cnt_d   = DivLast;
                        state_d = StDivIter;
                    end
                end
            end
            StMulIter: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    z_hi_d  = prod_step[2*WIDTH:WIDTH+1];
                    z_lo_d  = prod_step[WIDTH:1];
                    state_d = StDone;
                end
            end
            StDivIter: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                z_hi_d  = rem_res;
                z_lo_d  = quo_res;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            z_hi_q   <= '0;
            z_lo_q   <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            z_hi_q   <= z_hi_d;
            z_lo_q   <= z_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == StMulIter) || (state_q == StDivIter) ||
                             (state_q == StFixup);
    assign bus.done        = (state_q == StDone);
    assign bus.div_by_zero = dbz_q;
    assign bus.z_hi        = z_hi_q;
    assign bus.z_lo        = z_lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized operations.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int LAT_LIMIT = 60;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH(32)
    ) u_dut (
        .clock(clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic in 64 bits, avoiding any overflow.
    task automatic model(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (op_v == OP_MUL) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic scramble();
        bus.op        = 1'($urandom_range(0, 1));
        bus.operand_a = $urandom();
        bus.operand_b = $urandom();
    endtask

    // pulse_at/reset_at: cycle after the accepting edge (0 = not used).
    task automatic run_op(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                          input int pulse_at, input int reset_at);
        logic [31:0] ehi, elo;
        logic        edz;
        logic        seen;
        int          exp_lat, lat;
        model(op_v, a, b, ehi, elo, edz);
        if (op_v == OP_MUL) exp_lat = int'(MUL_LATENCY);
        else if (b == 32'd0) exp_lat = int'(DIVZ_LATENCY);
        else exp_lat = int'(DIV_LATENCY);

        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = op_v;
        bus.operand_a = a;
        bus.operand_b = b;
        lat = 0;
        for (int i = 1; i <= LAT_LIMIT; i++) begin
            @(negedge clk);
            if (i == 1 || i == pulse_at + 1) begin
                bus.start = 1'b0;
                scramble();
            end
            if (i == pulse_at) begin
                scramble();
                bus.start = 1'b1;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_busy", 64'(bus.busy), 64'(0));
                check("rst_done", 64'(bus.done), 64'(0));
                check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
                check("rst_z_hi", 64'(bus.z_hi), 64'(0));
                check("rst_z_lo", 64'(bus.z_lo), 64'(0));
                seen = 1'b0;
                for (int j = 0; j < 40; j++) begin
                    @(negedge clk);
                    if (bus.done) seen = 1'b1;
                end
                check("rst_no_done", 64'(seen), 64'(0));
                prev_hi = '0;
                prev_lo = '0;
                return;
            end
            check("busy", 64'(bus.busy), 64'(i < exp_lat));
            if (bus.done) begin
                lat = i;
                break;
            end
            check("hold_z_hi", 64'(bus.z_hi), 64'(prev_hi));
            check("hold_z_lo", 64'(bus.z_lo), 64'(prev_lo));
            check("dbz_run", 64'(bus.div_by_zero), 64'(edz));
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("z_hi", 64'(bus.z_hi), 64'(ehi));
        check("z_lo", 64'(bus.z_lo), 64'(elo));
        check("div_by_zero", 64'(bus.div_by_zero), 64'(edz));
        @(negedge clk);
        check("done_pulse", 64'(bus.done), 64'(0));
        check("after_z_hi", 64'(bus.z_hi), 64'(ehi));
        check("after_z_lo", 64'(bus.z_lo), 64'(elo));
        check("after_dbz", 64'(bus.div_by_zero), 64'(edz));
        prev_hi = ehi;
        prev_lo = elo;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        prev_hi       = '0;
        prev_lo       = '0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = OP_MUL;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_dbz", 64'(bus.div_by_zero), 64'(0));
        check("reset_z_hi", 64'(bus.z_hi), 64'(0));
        check("reset_z_lo", 64'(bus.z_lo), 64'(0));
        reset = 1'b0;

        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, 0, 0);
        run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op(OP_DIV, 32'd100, 32'd7, 0, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 0, 0);
        run_op(OP_MUL, 32'd9, 32'd11, 0, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(OP_MUL, 32'd123, 32'hFFFF_FFD3, 5, 0);
        run_op(OP_DIV, 32'hDEAD_BEEF, 32'd1234, 7, 0);
        run_op(OP_MUL, 32'd77, 32'd88, 0, 10);
        run_op(OP_DIV, 32'hFFFF_FC18, 32'd33, 0, 0);

        for (int n = 0; n < 30; n++) begin
            run_op(1'($urandom_range(0, 1)), pick(), pick(), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle signed multiply/divide unit feeding the Z_HI/Z_LO sources of the 32-source datapath bus selector. Operand A comes from the Y register and operand B from the bus. The result is held on z_hi/z_lo until the next accepted start, so the bus can select either half in any later cycle. The control unit launches an operation with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width; z_hi and z_lo are each WIDTH bits.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
op  input  1  0 = MUL, 1 = DIV
operand_a  input  WIDTH  multiplicand or dividend, from Y
operand_b  input  WIDTH  multiplier or divisor, from bus
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the result is valid
div_by_zero  output  1  sticky flag for the last DIV; cleared on the next accepted start
z_hi  output  WIDTH  MUL: product[63:32]; DIV: remainder
z_lo  output  WIDTH  MUL: product[31:0]; DIV: quotient

Behaviour:
- One clock and a synchronous, active-high reset; both are fixed.
- Reset values: busy=0, done=0, div_by_zero=0, z_hi=0, z_lo=0, state=IDLE.
- States and transitions:
  - IDLE: on start, latch op/operands. MUL -> MUL_ITER. DIV with operand_b≠0 -> DIV_ITER. DIV with operand_b=0 -> DONE.
  - MUL_ITER: radix-2 Booth, 32 iterations -> DONE.
  - DIV_ITER: non-restoring on magnitudes, 32 iterations -> FIXUP.
  - FIXUP: remainder restore, then sign correction -> DONE.
  - DONE: write z_hi/z_lo, pulse done, -> IDLE.
- All arithmetic is two's-complement signed.
- MUL: full 64-bit product, no overflow possible.
- DIV: quotient truncates toward zero; remainder takes the dividend's sign; |remainder| < |divisor|.
- Latency, with start accepted at edge k, done high in cycle:
  - MUL: k+33.
  - DIV: k+34.
  - DIV by zero: k+1.
- DIV by zero: z_lo=all ones, z_hi=operand_a, div_by_zero=1.
- 0x80000000 / -1 wraps: quotient=0x80000000, remainder=0, no flag.
- start while busy or while done is high: ignored, with no effect on the running operation.
- Operand inputs may change after the start cycle; the internal copies are used.
- z_hi/z_lo change only in the DONE cycle. The previous result stays visible on the bus until then.
- Reset mid-operation: abort immediately, all outputs return to reset values, no done pulse.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: MUL uses radix-4 Booth recoding with 16 iterations. MUL done at k+17. Results are bit-identical to radix-2.
- Undefined: radix-2 Booth, MUL done at k+33.
- DIV timing and behaviour are the same in both builds.

Decomposition:
- muldiv_pkg holds:
  - state enum: IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE.
  - OP_MUL=1'b0, OP_DIV=1'b1.
  - iteration-count constants MUL_ITERS, DIV_ITERS.
  - latency constants for the bench.
- One sub-module: nonrestoring_div_step. Combinational; takes the partial remainder, quotient and divisor magnitude and returns the next partial remainder and quotient bit. It is instantiated once and iterated by the FSM.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3) -> z_hi=0xFFFFFFFF, z_lo=0xFFFFFFEB. done exactly at k+33 (k+17 with MULDIV_FAST_MUL_EN). busy high k+1..k+32.
- MUL 0x80000000 × 0x80000000 -> z_hi=0x40000000, z_lo=0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 -> z_lo=0xFFFFFFFD, z_hi=0xFFFFFFFF, div_by_zero=0, done at k+34. Then DIV 100/7 -> z_lo=14, z_hi=2.
- DIV 5 / 0 -> done at k+1, div_by_zero=1, z_lo=0xFFFFFFFF, z_hi=5. Next MUL start -> div_by_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> z_lo=0x80000000, z_hi=0, div_by_zero=0.
- MUL started; start pulsed again at k+5 with new operands -> ignored, first result returned. Second run with reset at k+10 -> busy=0, z_hi=z_lo=0 next cycle, no done pulse; a fresh start afterwards completes normally.
